rtc_bus_driver: RTL and testbench

RTC_BUS_DRIVER -- requirements
Module: rtc_bus_driver

---
 rtl/rtc_bus_driver.sv | 136 +++++++++++++
 tb/tb_rtc_bus_driver.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rtc_bus_driver.sv
// Multiplexed address/data bus master for an RTC: address phase, data phase, done pulse.
// Optional macro RTC_BUS_GAP_EN inserts GAP1/GAP2 idle phases around the data phase.
module rtc_bus_driver #(
    parameter int PHASE_CYCLES = 10,
    parameter int GAP_CYCLES   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    inout  wire  [7:0] dato,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2, FIN} state_t;

    localparam logic [7:0] PH_LD = 8'(PHASE_CYCLES - 1);
`ifdef RTC_BUS_GAP_EN
    localparam logic [7:0] GAP_LD = 8'(GAP_CYCLES - 1);
`endif

    if (PHASE_CYCLES < 1 || PHASE_CYCLES > 255 || GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_cfg
        $error("rtc_bus_driver: PHASE_CYCLES/GAP_CYCLES must be 1..255");
    end

    state_t     r_state, w_nxt;
    logic [7:0] r_cnt, w_cnt;
    logic       r_rw;
    logic [7:0] r_wdata;
    logic [7:0] r_dout;
    logic       r_oe;

    assign dato = r_oe ? r_dout : 8'hzz;

    always_comb begin
        w_nxt = r_state;
        w_cnt = r_cnt;
        case (r_state)
            IDLE: if (start) begin
                w_nxt = ADDR;
                w_cnt = PH_LD;
            end
            ADDR: if (r_cnt == 8'd0) begin
`ifdef RTC_BUS_GAP_EN
                w_nxt = GAP1;
                w_cnt = GAP_LD;
`else
                w_nxt = DATA;
                w_cnt = PH_LD;
`endif
            end else begin
                w_cnt = r_cnt - 8'd1;
            end
`ifdef RTC_BUS_GAP_EN
            GAP1: if (r_cnt == 8'd0) begin
                w_nxt = DATA;
                w_cnt = PH_LD;
            end else begin
                w_cnt = r_cnt - 8'd1;
            end
            GAP2: if (r_cnt == 8'd0) begin
                w_nxt = FIN;
                w_cnt = 8'd0;
            end else begin
                w_cnt = r_cnt - 8'd1;
            end
`endif
            DATA: if (r_cnt == 8'd0) begin
`ifdef RTC_BUS_GAP_EN
                w_nxt = GAP2;
                w_cnt = GAP_LD;
`else
                w_nxt = FIN;
                w_cnt = 8'd0;
`endif
            end else begin
                w_cnt = r_cnt - 8'd1;
            end
            FIN: begin
                w_nxt = IDLE;
                w_cnt = 8'd0;
            end
            default: begin
                w_nxt = IDLE;
                w_cnt = 8'd0;
            end
        endcase
    end

    // Strobes are decoded from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_rw    <= 1'b0;
            r_wdata <= 8'h00;
            r_dout  <= 8'h00;
            r_oe    <= 1'b0;
            cs      <= 1'b1;
            wr      <= 1'b1;
            rd      <= 1'b1;
            a_d     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= 8'h00;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt;
            if (r_state == IDLE && start) begin
                r_rw    <= rw;
                r_wdata <= wdata;
                r_dout  <= addr;
            end else if (w_nxt == DATA && r_state != DATA) begin
                r_dout  <= r_wdata;
            end
            cs   <= !(w_nxt == ADDR || w_nxt == DATA);
            a_d  <= (w_nxt != ADDR);
            wr   <= !(w_nxt == ADDR || (w_nxt == DATA && !r_rw));
            rd   <= !(w_nxt == DATA && r_rw);
            r_oe <= (w_nxt == ADDR) || (w_nxt == DATA && !r_rw);
            busy <= (w_nxt != IDLE);
            done <= (w_nxt == FIN);
            if (r_state == DATA && r_cnt == 8'd0 && r_rw)
                rdata <= dato;
        end
    end

endmodule

// File: tb/tb_rtc_bus_driver.sv
// Bench for rtc_bus_driver: per-cycle bus timing table plus an rdata scoreboard popped on done.
module tb_rtc_bus_driver;

    localparam int P     = 4;
    localparam int G_CFG = 3;
`ifdef RTC_BUS_GAP_EN
    localparam int G = G_CFG;
`else
    localparam int G = 0;
`endif
    localparam int T = 2*P + 2*G + 1;
    localparam logic [13:0] IDLE_V = {6'b111100, 8'hFF};

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    wire  [7:0] dato;
    logic       a_d, cs, rd, wr, busy, done;
    logic [7:0] rdata;
    logic [7:0] tb_rd_val;

    // The RTC side: drives the bus only while the read strobe is low; pullups show a released bus as FFh.
    assign dato = (rd == 1'b0) ? tb_rd_val : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (dato[i]);
    end

    rtc_bus_driver #(.PHASE_CYCLES(P), .GAP_CYCLES(G_CFG)) dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .dato(dato), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr), .rdata(rdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_rdata = 8'h00;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // {cs, a_d, wr, rd, busy, done, dato} expected in cycle k after start is sampled.
    function automatic logic [13:0] exp_vec(input int k, input logic t_rw,
                                            input logic [7:0] a, input logic [7:0] wd,
                                            input logic [7:0] rv);
        if (k <= P)               return {6'b000110, a};
        else if (k <= P + G)      return {6'b111110, 8'hFF};
        else if (k <= 2*P + G)    return t_rw ? {6'b011010, rv} : {6'b010110, wd};
        else if (k <= 2*P + 2*G)  return {6'b111110, 8'hFF};
        else if (k == T)          return {6'b111111, 8'hFF};
        else                      return IDLE_V;
    endfunction

    function automatic logic [31:0] obs();
        return {18'd0, cs, a_d, wr, rd, busy, done, dato};
    endfunction

    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rdata", {24'd0, rdata}, {24'd0, e});
            end
        end
    end

    // Call at a falling edge; returns at the falling edge of the IDLE cycle after FIN.
    task automatic run_txn(input logic t_rw, input logic [7:0] a, input logic [7:0] wd,
                           input logic [7:0] rv, input int pa, input int pb, input bit keep);
        rw = t_rw; addr = a; wdata = wd; tb_rd_val = rv; start = 1'b1;
        if (t_rw) exp_rdata = rv;
        sb.push_back(exp_rdata);
        for (int k = 1; k <= T + 1; k++) begin
            @(negedge clk);
            chk($sformatf("%s a=%h cyc%0d", t_rw ? "rd" : "wr", a, k), obs(),
                {18'd0, exp_vec(k, t_rw, a, wd, rv)});
            if (k <= T) begin
                start = keep || (k == pa) || (k == pb);
                rw    = 1'($urandom);
                addr  = 8'($urandom);
                wdata = 8'($urandom);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00; tb_rd_val = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_bus", obs(), {18'd0, IDLE_V});
        chk("reset_rdata", {24'd0, rdata}, 32'd0);
        reset = 1'b0;

        run_txn(1'b0, 8'h21, 8'h45, 8'h00, 0, 0, 1'b0);
        run_txn(1'b1, 8'h22, 8'h00, 8'h59, 0, 0, 1'b0);
        // start pulses mid-transaction are ignored; rdata holds 59h through the write
        run_txn(1'b0, 8'h17, 8'h6A, 8'h00, 3, P + G + 3, 1'b0);

        // start held high: one IDLE cycle between transactions
        run_txn(1'b1, 8'h30, 8'h00, 8'hA5, 0, 0, 1'b1);
        run_txn(1'b0, 8'h31, 8'h7E, 8'h00, 0, 0, 1'b1);
        run_txn(1'b1, 8'h32, 8'h00, 8'h3C, 0, 0, 1'b0);

        // reset in the middle of a write's data phase
        rw = 1'b0; addr = 8'h33; wdata = 8'h44; start = 1'b1;
        for (int k = 1; k <= P + G + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("abort_bus", obs(), {18'd0, IDLE_V});
        chk("abort_rdata", {24'd0, rdata}, 32'd0);
        exp_rdata = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        run_txn(1'b0, 8'h34, 8'h12, 8'h00, 0, 0, 1'b0);

        for (int i = 0; i < 4; i++)
            run_txn(1'($urandom), 8'($urandom_range(0, 254)), 8'($urandom_range(0, 254)),
                    8'($urandom_range(0, 254)), 0, 0, 1'($urandom));
        start = 1'b0;
        repeat (T + 2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        chk("final_idle", obs(), {18'd0, IDLE_V});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
